// File: rtl/mips_dmem_responder_if.sv
// Load/store request and response bundle between the core (master) and the
// data-memory responder (slave).
interface mips_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mips_dmem_responder.sv
// Fixed-latency word data memory that sits behind the core's load/store path.
// One request is taken at a time. The response appears LATENCY cycles after
// the accept edge, as a one-cycle strobe. Storage is internal and not reset.
module mips_dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mips_dmem_responder_if.slave bus
);
  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, next_state;
  logic [3:0]  count, next_count;
  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        ready_q;
  logic        valid_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          eff_write;
  logic [31:0]   eff_addr;
  logic [31:0]   eff_wdata;
  logic          eff_err;
  logic [AW-1:0] eff_idx;

  // An address is bad if it is not word aligned or lies beyond the storage.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
  endfunction

  assign accept = (state == IDLE) && ready_q && bus.req_valid;

  // With LATENCY==1, RESP is entered on the accept edge itself. At that point
  // the captured copy does not exist yet, so the live request is used instead.
  assign eff_write = (state == IDLE) ? bus.req_write : cap_write;
  assign eff_addr  = (state == IDLE) ? bus.req_addr  : cap_addr;
  assign eff_wdata = (state == IDLE) ? bus.req_wdata : cap_wdata;
  assign eff_err   = addr_bad(eff_addr);
  assign eff_idx   = eff_addr[AW+1:2];

  assign enter_resp = (next_state == RESP) && (state != RESP);

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // Next-state logic: count down the latency, then present one response cycle.
  always_comb begin
    next_state = state;
    next_count = count;
    case (state)
      IDLE: begin
        if (accept) begin
          next_count = LAT_M1;
          next_state = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        next_count = count - 4'd1;
        if (count == 4'd1) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register, request capture and registered response outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
      if (accept) begin
        cap_write <= bus.req_write;
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
      end
      ready_q <= (next_state == IDLE);
      valid_q <= (next_state == RESP);
      err_q   <= enter_resp && eff_err;
      rdata_q <= (enter_resp && !eff_write && !eff_err) ? mem[eff_idx] : 32'd0;
    end
  end

  // A store commits on the edge that enters RESP. An aborted transaction never gets here.
  always_ff @(posedge clock) begin
    if (reset_n && enter_resp && eff_write && !eff_err) mem[eff_idx] <= eff_wdata;
  end
endmodule
